// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: 4-digit BCD stopwatch controller (0000-9999).
//   Debounces two raw active-low pushbuttons. Runs an IDLE/RUN/PAUSE/LAP
//   state machine. Divides clk down to the count tick and drives either the
//   live BCD count or a frozen lap value.
// Ports:
//   clk          system clock
//   reset        synchronous, active-low
//   key_start_n  raw start/stop key (active-low, async, bouncy)
//   key_lap_n    raw lap/clear key (active-low, async, bouncy)
//   digits       {d3,d2,d1,d0} BCD; live count or lap value
//   count_en     one-cycle pulse per count increment
//   running      high in RUN and LAP
//   lap_hold     high while digits shows the lap value
//   overflow     sticky 9999->0000 wrap flag, cleared on IDLE entry

// Per-key synchronizer + debouncer + press (falling-edge) detector.
module stopwatch_key_deb #(
  parameter int DEB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_key_n,
  output logic o_press
);
  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_TOP = CW'(DEB_CYCLES - 1);

  logic          r_s1, r_s2, r_deb, r_deb_d, r_press;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_deb   <= 1'b1;
      r_deb_d <= 1'b1;
      r_press <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1    <= i_key_n;
      r_s2    <= r_s1;
      r_deb_d <= r_deb;
      // registered edge detect: one stage after the debounced level falls
      r_press <= r_deb_d & ~r_deb;
      if (r_s2 == r_deb) begin
        r_cnt <= '0;                   // any agreement restarts the run
      end else if (r_cnt == CNT_TOP) begin
        r_deb <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

module stopwatch_ctrl #(
  parameter int TICK_DIV   = 500000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        key_start_n,
  input  logic        key_lap_n,
  output logic [15:0] digits,
  output logic        count_en,
  output logic        running,
  output logic        lap_hold,
  output logic        overflow
);
  localparam int PW = $clog2(TICK_DIV + 1);
  localparam logic [PW-1:0] PRE_TOP = PW'(TICK_DIV - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_LAP} state_t;

  logic [1:0] w_keys_n, w_press;
  assign w_keys_n = {key_lap_n, key_start_n};

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_key
      stopwatch_key_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
        .clk     (clk),
        .reset   (reset),
        .i_key_n (w_keys_n[g]),
        .o_press (w_press[g])
      );
    end
  endgenerate

  state_t             r_state, w_state_nxt;
  logic [PW-1:0]      r_presc, w_presc_nxt;
  logic [3:0][3:0]    r_count, r_lap, w_cnt_inc, w_count_nxt, w_lap_nxt;
  logic [15:0]        r_digits;
  logic               r_count_en, r_running, r_lap_hold, r_ovf;
  logic               w_start, w_lap, w_capture, w_clear;
  logic               w_active, w_tick, w_carry, w_wrap, w_ovf_nxt, w_hold_nxt;

  // Next-state logic; start wins over lap when both arrive together.
  always_comb begin
    w_start     = w_press[0];
    w_lap       = w_press[1];
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_clear     = 1'b0;
    unique case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_RUN;
      S_RUN:   if (w_start) w_state_nxt = S_PAUSE;
               else if (w_lap) begin w_state_nxt = S_LAP; w_capture = 1'b1; end
      S_LAP:   if (w_start) w_state_nxt = S_PAUSE;
               else if (w_lap) w_state_nxt = S_RUN;
      S_PAUSE: if (w_start) w_state_nxt = S_RUN;
               else if (w_lap) begin w_state_nxt = S_IDLE; w_clear = 1'b1; end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Tick uses the current state, so the last RUN cycle before PAUSE still counts.
  always_comb begin
    w_active = (r_state == S_RUN) || (r_state == S_LAP);
    w_tick   = w_active && (r_presc == PRE_TOP);
    if (w_clear || r_state == S_IDLE) w_presc_nxt = '0;
    else if (w_active)                w_presc_nxt = w_tick ? '0 : r_presc + 1'b1;
    else                              w_presc_nxt = r_presc;   // PAUSE: exact resume
  end

  // Cascaded BCD increment; carry out of d3 is the 9999->0000 wrap.
  always_comb begin
    w_cnt_inc = r_count;
    w_carry   = w_tick;
    for (int i = 0; i < 4; i++) begin
      if (w_carry) begin
        if (r_count[i] == 4'd9) begin
          w_cnt_inc[i] = 4'd0;
        end else begin
          w_cnt_inc[i] = r_count[i] + 4'd1;
          w_carry      = 1'b0;
        end
      end
    end
    w_wrap      = w_carry;
    w_count_nxt = w_clear ? '0 : w_cnt_inc;
    w_lap_nxt   = w_capture ? r_count : r_lap;   // pre-increment value
    w_ovf_nxt   = !w_clear && (r_ovf || w_wrap);
    w_hold_nxt  = (w_state_nxt == S_LAP);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_presc    <= '0;
      r_count    <= '0;
      r_lap      <= '0;
      r_digits   <= '0;
      r_count_en <= 1'b0;
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_presc    <= w_presc_nxt;
      r_count    <= w_count_nxt;
      r_lap      <= w_lap_nxt;
      r_digits   <= w_hold_nxt ? w_lap_nxt : w_count_nxt;
      r_count_en <= w_tick;
      r_running  <= (w_state_nxt == S_RUN) || (w_state_nxt == S_LAP);
      r_lap_hold <= w_hold_nxt;
      r_ovf      <= w_ovf_nxt;
    end
  end

  assign digits   = r_digits;
  assign count_en = r_count_en;
  assign running  = r_running;
  assign lap_hold = r_lap_hold;
  assign overflow = r_ovf;
endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;
  logic clk = 1'b0;
  logic reset;
  logic s0, l0, s1, l1;
  logic [15:0] dig0, dig1;
  logic ce0, run0, lh0, ov0, ce1, run1, lh1, ov1;

  int nchk = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  stopwatch_ctrl #(.TICK_DIV(4), .DEB_CYCLES(3)) dut0 (
    .clk(clk), .reset(reset), .key_start_n(s0), .key_lap_n(l0),
    .digits(dig0), .count_en(ce0), .running(run0), .lap_hold(lh0), .overflow(ov0));

  stopwatch_ctrl #(.TICK_DIV(1), .DEB_CYCLES(3)) dut1 (
    .clk(clk), .reset(reset), .key_start_n(s1), .key_lap_n(l1),
    .digits(dig1), .count_en(ce1), .running(run1), .lap_hold(lh1), .overflow(ov1));

  typedef struct {
    logic        sn;
    logic        ln;
    int          cyc;
    logic [19:0] exp;  // {running, lap_hold, overflow, count_en, digits}
  } vec_t;

  vec_t tbl[$];

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [19:0] got, input logic [19:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got run=%b lh=%b ovf=%b ce=%b dig=%h, expected run=%b lh=%b ovf=%b ce=%b dig=%h",
               name, got[19], got[18], got[17], got[16], got[15:0],
               exp[19], exp[18], exp[17], exp[16], exp[15:0]);
    end
  endtask

  task automatic add(input logic sn, input logic ln, input int cyc, input logic r,
                     input logic lh, input logic ov, input logic ce, input logic [15:0] d);
    vec_t v;
    v.sn = sn; v.ln = ln; v.cyc = cyc; v.exp = {r, lh, ov, ce, d};
    tbl.push_back(v);
  endtask

  function automatic logic [19:0] out0();
    return {run0, lh0, ov0, ce0, dig0};
  endfunction

  function automatic logic [19:0] out1();
    return {run1, lh1, ov1, ce1, dig1};
  endfunction

  initial begin
    // key, hold cycles, expected outputs after the hold (edge index in comment)
    add(0,1,  4, 0,0,0,0,16'h0000);  // e4   press start, debouncing
    add(1,1,  2, 0,0,0,0,16'h0000);  // e6   one edge before latency
    add(1,1,  1, 1,0,0,0,16'h0000);  // e7   running exactly DEB+3 after first low
    add(1,1,  4, 1,0,0,1,16'h0001);  // e11  first tick TICK_DIV after rise
    add(1,1,156, 1,0,0,1,16'h0040);  // e167 160 cycles of RUN
    add(1,1,  2, 1,0,0,0,16'h0040);  // e169
    add(0,1,  4, 1,0,0,0,16'h0041);  // e173 press start (pause)
    add(1,1,  3, 0,0,0,0,16'h0042);  // e176 PAUSE; tick in last RUN cycle applied
    add(1,1, 20, 0,0,0,0,16'h0042);  // e196 frozen
    add(0,1,  4, 0,0,0,0,16'h0042);  // e200 press start (resume)
    add(1,1,  3, 1,0,0,0,16'h0042);  // e203 RUN, prescaler resumes at 1
    add(1,1,  2, 1,0,0,0,16'h0042);  // e205
    add(1,1,  1, 1,0,0,1,16'h0043);  // e206 tick after 3, not 4
    add(1,0,  4, 1,0,0,1,16'h0044);  // e210 press lap
    add(1,1,  3, 1,1,0,0,16'h0044);  // e213 LAP, captured 44
    add(1,1,  1, 1,1,0,1,16'h0044);  // e214 count_en still pulses
    add(1,1, 20, 1,1,0,1,16'h0044);  // e234 live count 50, display frozen
    add(1,0,  4, 1,1,0,1,16'h0044);  // e238 press lap again
    add(1,1,  3, 1,0,0,0,16'h0051);  // e241 back to live
    add(1,1, 10, 1,0,0,0,16'h0054);  // e251
    add(0,0,  4, 1,0,0,0,16'h0055);  // e255 start + lap together
    add(1,1,  3, 0,0,0,1,16'h0056);  // e258 PAUSE, lap dropped
    add(1,1, 10, 0,0,0,0,16'h0056);  // e268
    add(1,0,  4, 0,0,0,0,16'h0056);  // e272 lap in PAUSE
    add(1,1,  3, 0,0,0,0,16'h0000);  // e275 IDLE, cleared
    add(1,1, 10, 0,0,0,0,16'h0000);  // e285
    add(1,0,  4, 0,0,0,0,16'h0000);  // e289 lap in IDLE
    add(1,1, 10, 0,0,0,0,16'h0000);  // e299 ignored
    add(0,1,  4, 0,0,0,0,16'h0000);  // e303 start from IDLE
    add(1,1,  3, 1,0,0,0,16'h0000);  // e306
    add(1,1,  3, 1,0,0,0,16'h0000);  // e309
    add(1,1,  1, 1,0,0,1,16'h0001);  // e310 prescaler restarted from 0
    add(1,0,  4, 1,0,0,1,16'h0002);  // e314 press lap
    add(1,1,  3, 1,1,0,0,16'h0002);  // e317 LAP holding 2
    add(1,1, 10, 1,1,0,0,16'h0002);  // e327
    add(0,1,  4, 1,1,0,0,16'h0002);  // e331 start in LAP
    add(1,1,  3, 0,0,0,1,16'h0007);  // e334 PAUSE, live shown, last tick applied

    // reset with keys toggling every cycle
    reset = 1'b0; s0 = 1'b0; l0 = 1'b1; s1 = 1'b1; l1 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      chk($sformatf("rst_hold0_%0d", i), out0(), 20'h0);
      chk($sformatf("rst_hold1_%0d", i), out1(), 20'h0);
      s0 = ~s0; l0 = ~l0; s1 = ~s1; l1 = ~l1;
    end
    reset = 1'b1; s0 = 1'b1; l0 = 1'b1; s1 = 1'b1; l1 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step(1);
      chk($sformatf("rst_quiet_%0d", i), out0(), 20'h0);
    end

    // bounce: low 2, high 1, low 2, then high
    s0 = 1'b0; step(2); s0 = 1'b1; step(1); s0 = 1'b0; step(2); s0 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step(1);
      chk($sformatf("bounce_%0d", i), out0(), 20'h0);
    end

    for (int i = 0; i < tbl.size(); i++) begin
      s0 = tbl[i].sn; l0 = tbl[i].ln;
      step(tbl[i].cyc);
      chk($sformatf("vec%0d", i), out0(), tbl[i].exp);
    end
    s0 = 1'b1; l0 = 1'b1;

    // wrap with TICK_DIV=1
    s1 = 1'b0; step(4); s1 = 1'b1; step(3);
    chk("wrap_start", out1(), {4'b1000, 16'h0000});
    step(9999);
    chk("wrap_9999", out1(), {4'b1001, 16'h9999});
    step(1);
    chk("wrap_0000", out1(), {4'b1011, 16'h0000});
    s1 = 1'b0; step(4); s1 = 1'b1; step(3);
    chk("wrap_pause", out1(), {4'b0011, 16'h0007});
    step(5);
    l1 = 1'b0; step(4); l1 = 1'b1; step(2);
    chk("wrap_pre_clear", out1(), {4'b0010, 16'h0007});
    step(1);
    chk("wrap_clear", out1(), 20'h0);

    // reset mid-LAP with start held low through release
    s0 = 1'b0; step(4); s0 = 1'b1; step(3);
    chk("mid_run", {19'b0, run0}, 20'd1);
    step(8);
    l0 = 1'b0; step(4); l0 = 1'b1; step(3);
    chk("mid_lap", {19'b0, lh0}, 20'd1);
    step(7);
    reset = 1'b0; s0 = 1'b0;
    step(1);
    chk("mid_rst0", out0(), 20'h0);
    step(1);
    chk("mid_rst1", out0(), 20'h0);
    reset = 1'b1;
    step(6);
    chk("held_key_pre", out0(), 20'h0);
    step(1);
    chk("held_key_run", out0(), {4'b1000, 16'h0000});
    s0 = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Stopwatch controller for the DE10-Lite seven-segment datapath. It debounces two raw pushbuttons, runs a start/stop/lap/clear state machine, and generates the timebase tick. It sequences a 4-digit cascaded BCD count (0000–9999) and presents either the live count or a frozen lap value. Its BCD outputs feed the existing per-digit BCD-to-seven-segment decoders.

## Interface

- TICK_DIV, default 500000: clk cycles per count increment (50 MHz → 100 Hz, 0.01 s resolution); legal range ≥1.
- DEB_CYCLES, default 1000000: consecutive stable cycles required for a key level change (20 ms at 50 MHz); legal range ≥1.

- clk  input  1  system clock, single clock domain.
- reset  input  1  synchronous, active-low reset.
- key_start_n  input  1  raw start/stop pushbutton, active-low, asynchronous to clk, may bounce.
- key_lap_n  input  1  raw lap/clear pushbutton, active-low, asynchronous, may bounce.
- digits  output  16  BCD digits {d3,d2,d1,d0}, d0 least significant; live count or lap value.
- count_en  output  1  one-cycle pulse on each count increment.
- running  output  1  high in RUN and LAP.
- lap_hold  output  1  high while digits shows the frozen lap value.
- overflow  output  1  sticky; set when the count wraps 9999→0000.

## Operation

- Key path, per key:
  - 2-flop synchronizer, reset value 1.
  - Debounce counter; the debounced level (reset 1) takes the synchronized value after it differs from the current debounced level for DEB_CYCLES consecutive cycles. Any mismatch break restarts the count.
  - A press event is a one-cycle pulse on the debounced 1→0 transition. Release generates no event.
- FSM states are IDLE, RUN, PAUSE and LAP. Reset state is IDLE.
  - IDLE: start → RUN. Lap is ignored.
  - RUN: start → PAUSE. Lap → LAP and captures the count into the lap register.
  - LAP: lap → RUN, display returns to live. Start → PAUSE, lap_hold clears and display shows live.
  - PAUSE: start → RUN. Lap → IDLE, clearing count, prescaler and overflow.
  - Start and lap events in the same cycle: start has priority and lap is dropped.
- Prescaler:
  - Counts 0..TICK_DIV-1 while in RUN or LAP. Tick fires when it equals TICK_DIV-1, then it wraps to 0.
  - Holds its value in PAUSE, so resume is exact. Held at 0 in IDLE.
- BCD count:
  - On each tick, d0 increments. Each digit wraps 9→0 and carries into the next digit.
  - 9999→0000 sets overflow, which stays set until IDLE entry or reset.
  - Digit values never exceed 9.
- Lap capture takes the count register value present in the capture cycle, before that cycle's increment.
- digits = lap_hold ? lap register : count register.

## Timing

- All outputs are registered.
- Reset values (reset low at a clk edge): digits=0x0000, count_en=0, running=0, lap_hold=0, overflow=0, FSM=IDLE, prescaler=0, lap register=0, all key flops=1.
- Key latency: a clean press first sampled low at edge N produces its FSM state change, visible on running/lap_hold, at edge N+DEB_CYCLES+3.
- Tick decision uses the current state:
  - A tick in the last RUN cycle before a transition to PAUSE is applied.
  - The first tick after IDLE→RUN occurs TICK_DIV cycles after running rises.
- count_en and the digits update occur at the same edge.
- TICK_DIV=1: count_en is high every cycle in RUN/LAP.
- Reset mid-operation (any state, mid-debounce, mid-prescale) returns everything to reset values at that edge. A key held low through reset release generates a press event after the debounce latency.

## Test plan

Parameters: TICK_DIV=4, DEB_CYCLES=3 unless noted.

- Reset: hold reset low 5 cycles while toggling both keys every cycle → all outputs 0 throughout, and no state change for DEB_CYCLES+3 cycles after release with keys high.
- Bounce rejection: key_start_n low for 2 cycles, high 1, low 2, then high → running stays 0. A clean press held 10 cycles → running=1 exactly DEB_CYCLES+3 edges after the first low sample.
- Counting: start, run 160 cycles → count_en pulses every 4th cycle, digits=0x0040. Press start → PAUSE, digits frozen. Press start again → next tick arrives after the remaining prescale cycles, not after 4.
- Lap: during RUN at digits=0x0012, press lap → lap_hold=1 and digits holds 0x0012 while count_en keeps pulsing. Press lap → digits shows the live value (e.g. 0x0020). Press start and lap in the same cycle from RUN → PAUSE, lap_hold=0.
- Wrap/clear: with TICK_DIV=1, run 10000 ticks → digits=0x0000, overflow=1. Pause, then press lap → IDLE, overflow=0, running=0.
- Reset mid-run: assert reset at digits=0x0345 in LAP → next edge all outputs 0, FSM IDLE.
